div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider in the EX stage, directly downstream of the ID/EX pipeline register.
- Takes the two operand registers and the divide aluop (DIV/DIVU) that ID/EX delivers for issue slot 1.
- Produces {remainder, quotient} for the HI/LO write path.
- Raises a stall request that freezes IF–EX until the result is ready; a pipeline flush cancels it.

---
 rtl/div_unit_pkg.sv | 15 +
 rtl/div_unit_if.sv | 21 ++
 rtl/div_unit.sv | 175 +++++++++++++++++
 tb/tb_div_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared types for the multi-cycle EX-stage divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_START              = 1'b1;
  localparam logic DIV_RESULT_READY       = 1'b1;
  localparam logic DIV_RESULT_NOT_READY   = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// EX-stage <-> divider handshake: operands and control in, {rem, quo} and stall out.
interface div_unit_if #(parameter int WIDTH = 32);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stall_req_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stall_req_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stall_req_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; result {remainder, quotient} for HI/LO.
// Optional DIV_EARLY_OUT_EN: |dividend| < |divisor| skips the iteration loop.
//
// state       | meaning
// DIV_FREE    | idle, waiting for start_i
// DIV_BY_ZERO | one-cycle short path (divide by zero, or early-out result in rem_q)
// DIV_ON      | one restoring step per cycle, 32 steps
// DIV_END     | result held until EX drops start_i
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               sgn_q, sgn_d;
  logic               neg1_q, neg1_d;
  logic               neg2_q, neg2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;
  logic               op1_neg;
  logic               op2_neg;
  logic [WIDTH-1:0]   fin_quo;
  logic [WIDTH-1:0]   fin_rem;

  function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0] a, input logic [WIDTH-1:0] b);
    return a - {1'b0, b};
  endfunction

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  always_comb begin
    op1_neg = bus.signed_i & bus.opdata1_i[WIDTH-1];
    op2_neg = bus.signed_i & bus.opdata2_i[WIDTH-1];
    abs1    = op1_neg ? negate(bus.opdata1_i) : bus.opdata1_i;
    abs2    = op2_neg ? negate(bus.opdata2_i) : bus.opdata2_i;

    // A 33-bit difference is enough: bit WIDTH is set exactly when the trial goes negative.
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = trial_sub(rem_sh, dvsr_q);
    if (!diff[WIDTH]) begin
      step_rem = diff[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_rem = rem_sh[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b0};
    end
    fin_quo = (sgn_q && (neg1_q ^ neg2_q)) ? negate(step_quo) : step_quo;
    fin_rem = (sgn_q && neg1_q) ? negate(step_rem) : step_rem;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    sgn_d    = sgn_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = ready_q;

    unique case (state_q)
      DIV_FREE: begin
        if (bus.start_i == DIV_START) begin
          if (bus.opdata2_i == '0) begin
            rem_d   = '0;
            state_d = DIV_BY_ZERO;
          end else
`ifdef DIV_EARLY_OUT_EN
          if (abs1 < abs2) begin
            rem_d   = bus.opdata1_i;
            state_d = DIV_BY_ZERO;
          end else
`endif
          begin
            rem_d   = '0;
            quo_d   = abs1;
            dvsr_d  = abs2;
            sgn_d   = bus.signed_i;
            neg1_d  = op1_neg;
            neg2_d  = op2_neg;
            cnt_d   = '0;
            state_d = DIV_ON;
          end
        end
      end
      DIV_BY_ZERO: begin
        result_d = {rem_q, {WIDTH{1'b0}}};
        ready_d  = DIV_RESULT_READY;
        state_d  = DIV_END;
      end
      DIV_ON: begin
        if (!bus.start_i) begin
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
          state_d  = DIV_FREE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_d = {fin_rem, fin_quo};
            ready_d  = DIV_RESULT_READY;
            state_d  = DIV_END;
          end
        end
      end
      DIV_END: begin
        if (!bus.start_i) begin
          ready_d = DIV_RESULT_NOT_READY;
          state_d = DIV_FREE;
        end
      end
      default: state_d = DIV_FREE;
    endcase

    // Flush wins over everything, including a start in the same cycle.
    if (bus.annul_i) begin
      result_d = '0;
      ready_d  = DIV_RESULT_NOT_READY;
      state_d  = DIV_FREE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      sgn_q    <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      sgn_q    <= sgn_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o    = result_q;
  assign bus.ready_o     = ready_q;
  assign bus.stall_req_o = bus.start_i & ~ready_q & ~bus.annul_i;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: vector table plus annul/reset/start-drop sequences.
module tb_div_unit;

  logic clk;
  logic rst;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        eo;
    logic [63:0] exp_res;
  } vec_t;

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are already presented; waits for ready_o, checking latency and stall cycles.
  task automatic wait_ready(input string name, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    int stl;
    lat = 0;
    stl = 0;
    while (!bus.ready_o && lat < 60) begin
      #1;
      if (bus.stall_req_o) stl++;
      tick();
      lat++;
      if (lat == 1) begin
        bus.opdata1_i = 32'hDEAD_BEEF;
        bus.opdata2_i = 32'h0000_0003;
      end
    end
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_stall_cycles"}, 64'(stl), 64'(exp_lat));
    chk({name, "_result"}, bus.result_o, exp_res);
  endtask

  task automatic release_start(input string name);
    #1;
    chk({name, "_stall_at_ready"}, 64'(bus.stall_req_o), 64'(0));
    bus.start_i = 1'b0;
    tick();
    chk({name, "_ready_cleared"}, 64'(bus.ready_o), 64'(0));
  endtask

  task automatic do_div(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    bus.signed_i  = sgn;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.start_i   = 1'b1;
    wait_ready(name, exp_res, exp_lat);
    release_start(name);
  endtask

  vec_t vecs[$];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    bus.start_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.annul_i   = 1'b0;
    rst = 1'b1;

    vecs.push_back('{"divu_100_7",      1'b0, 32'd100,       32'd7,         1'b0, {32'h2,        32'hE}});
    vecs.push_back('{"div_m7_2",        1'b1, 32'hFFFF_FFF9, 32'h2,         1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}});
    vecs.push_back('{"div_7_m2",        1'b1, 32'h7,         32'hFFFF_FFFE, 1'b0, {32'h1,        32'hFFFF_FFFD}});
    vecs.push_back('{"div_min_m1",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h0,        32'h8000_0000}});
    vecs.push_back('{"divu_5_0",        1'b0, 32'd5,         32'd0,         1'b0, 64'h0});
    vecs.push_back('{"div_m5_0",        1'b1, 32'hFFFF_FFFB, 32'd0,         1'b0, 64'h0});
    vecs.push_back('{"divu_3_10",       1'b0, 32'd3,         32'd10,        1'b1, {32'h3,        32'h0}});
    vecs.push_back('{"divu_max_1",      1'b0, 32'hFFFF_FFFF, 32'd1,         1'b0, {32'h0,        32'hFFFF_FFFF}});
    vecs.push_back('{"divu_max_max",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'h0,        32'h1}});
    vecs.push_back('{"div_m7_m2",       1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, {32'hFFFF_FFFF, 32'h3}});
    vecs.push_back('{"divu_hex",        1'b0, 32'h1234_5678, 32'h0000_1000, 1'b0, {32'h678,      32'h12345}});
    vecs.push_back('{"divu_8000_ffff",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'h0}});
    vecs.push_back('{"div_m3_10",       1'b1, 32'hFFFF_FFFD, 32'd10,        1'b1, {32'hFFFF_FFFD, 32'h0}});
    vecs.push_back('{"div_0_5",         1'b1, 32'h0,         32'd5,         1'b1, 64'h0});

    repeat (3) tick();
    chk("reset_ready", 64'(bus.ready_o), 64'(0));
    chk("reset_result", bus.result_o, 64'h0);
    bus.start_i = 1'b1;
    #1;
    chk("reset_stall_start_high", 64'(bus.stall_req_o), 64'(1));
    bus.start_i = 1'b0;
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      int lat;
      lat = (vecs[i].b == 32'h0 || (EARLY && vecs[i].eo)) ? 2 : 33;
      do_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp_res, lat);
    end

    // Annul in the middle of ON, then a fresh divide.
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    repeat (11) tick();
    bus.annul_i = 1'b1;
    #1;
    chk("annul_stall_comb", 64'(bus.stall_req_o), 64'(0));
    tick();
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    #1;
    chk("annul_ready", 64'(bus.ready_o), 64'(0));
    chk("annul_result", bus.result_o, 64'h0);
    chk("annul_stall", 64'(bus.stall_req_o), 64'(0));
    do_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33);

    // Annul with start in IDLE must be ignored (divide-by-zero would be ready in 2).
    bus.opdata1_i = 32'd5;
    bus.opdata2_i = 32'd0;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    repeat (3) tick();
    chk("annul_idle_ready", 64'(bus.ready_o), 64'(0));
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    tick();

    // start_i dropping during ON behaves like annul.
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (6) tick();
    bus.start_i = 1'b0;
    repeat (40) tick();
    chk("start_drop_ready", 64'(bus.ready_o), 64'(0));
    chk("start_drop_result", bus.result_o, 64'h0);
    do_div("after_drop_100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);

    // Reset at ON step 20 with start held; restart after reset deasserts.
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (21) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_ready", 64'(bus.ready_o), 64'(0));
    chk("rst_mid_result", bus.result_o, 64'h0);
    rst = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    wait_ready("rst_restart", {32'h2, 32'hE}, 33);

    // Reset while the result is being held in END.
    rst = 1'b1;
    tick();
    chk("rst_end_ready", 64'(bus.ready_o), 64'(0));
    chk("rst_end_result", bus.result_o, 64'h0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
